control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microprogrammed-style control unit for a single-accumulator
//                datapath. Steps through a six-step fetch (F0..F5), decodes
//                the registered opcode, and runs one or two execute steps
//                (E0/E1) before returning straight to F0. HALT parks the
//                block in HALTED until reset.
//
//  Ports
//    i_clk          in   1   rising-edge clock
//    i_rst          in   1   asynchronous, active-high reset
//    i_start        in   1   begin processing (only honoured in IDLE)
//    i_ir_cu        in   8   opcode from IR (captured at the end of F3)
//    i_acc_nonneg   in   1   ACC[15]==0, qualifies JMPGEZ
//    o_ctrl         out 16   control word C15..C0
//    o_alu_op       out  4   ALU function (non-zero only with C6)
//    o_busy         out  1   high outside IDLE and HALTED
//    o_instr_done   out  1   pulse in the last step of each instruction
//    o_halted       out  1   high while in HALTED
//
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_ir_cu,
    input  logic        i_acc_nonneg,
    output logic [15:0] o_ctrl,
    output logic [3:0]  o_alu_op,
    output logic        o_busy,
    output logic        o_instr_done,
    output logic        o_halted
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_F3     = 4'd4,
        S_F4     = 4'd5,
        S_F5     = 4'd6,
        S_E0     = 4'd7,
        S_E1     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    // Opcodes
    localparam logic [7:0] c_OP_STORE  = 8'h01;
    localparam logic [7:0] c_OP_LOAD   = 8'h02;
    localparam logic [7:0] c_OP_ADD    = 8'h03;
    localparam logic [7:0] c_OP_SUB    = 8'h04;
    localparam logic [7:0] c_OP_JMPGEZ = 8'h05;
    localparam logic [7:0] c_OP_JMP    = 8'h06;
    localparam logic [7:0] c_OP_HALT   = 8'h07;
    localparam logic [7:0] c_OP_MPY    = 8'h08;
    localparam logic [7:0] c_OP_AND    = 8'h09;
    localparam logic [7:0] c_OP_OR     = 8'h0A;
    localparam logic [7:0] c_OP_NOT    = 8'h0B;
    localparam logic [7:0] c_OP_SHR    = 8'h0C;
    localparam logic [7:0] c_OP_SHL    = 8'h0D;

    // ALU function codes
    localparam logic [3:0] c_ALU_PASS = 4'd0;
    localparam logic [3:0] c_ALU_ADD  = 4'd1;
    localparam logic [3:0] c_ALU_SUB  = 4'd2;
    localparam logic [3:0] c_ALU_AND  = 4'd3;
    localparam logic [3:0] c_ALU_OR   = 4'd4;
    localparam logic [3:0] c_ALU_NOT  = 4'd5;
    localparam logic [3:0] c_ALU_SHR  = 4'd6;
    localparam logic [3:0] c_ALU_SHL  = 4'd7;
    localparam logic [3:0] c_ALU_MPY  = 4'd8;

    // Control-word bits
    localparam logic [15:0] c_C0  = 16'h0001;
    localparam logic [15:0] c_C1  = 16'h0002;
    localparam logic [15:0] c_C2  = 16'h0004;
    localparam logic [15:0] c_C3  = 16'h0008;
    localparam logic [15:0] c_C4  = 16'h0010;
    localparam logic [15:0] c_C5  = 16'h0020;
    localparam logic [15:0] c_C6  = 16'h0040;
    localparam logic [15:0] c_C7  = 16'h0080;
    localparam logic [15:0] c_C8  = 16'h0100;
    localparam logic [15:0] c_C9  = 16'h0200;
    localparam logic [15:0] c_C14 = 16'h4000;
    localparam logic [15:0] c_C15 = 16'h8000;

    state_t      r_state;
    logic [7:0]  r_opcode;
    logic [15:0] r_ctrl;
    logic [3:0]  r_alu_op;
    logic        r_busy;
    logic        r_done;
    logic        r_halted;
    logic        r_jmpgez_e0;   // in E0 of a JMPGEZ; C3 is qualified live

    state_t      w_nxt_state;
    logic [7:0]  w_nxt_opcode;
    logic [15:0] w_nxt_ctrl;
    logic [3:0]  w_nxt_alu_op;
    logic        w_nxt_done;
    logic        w_nxt_jmpgez;
    logic        w_mem_alu;     // two-step ALU op with memory operand
    logic        w_two_step;    // instruction needs E1
    logic [3:0]  w_alu_sel;

    // Classify the opcode that will be in the register next cycle, so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        w_mem_alu = 1'b0;
        w_alu_sel = c_ALU_PASS;
        case (w_nxt_opcode)
            c_OP_LOAD: begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_PASS; end
            c_OP_ADD:  begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_ADD;  end
            c_OP_SUB:  begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_SUB;  end
            c_OP_AND:  begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_AND;  end
            c_OP_OR:   begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_OR;   end
            c_OP_MPY:  begin w_mem_alu = 1'b1; w_alu_sel = c_ALU_MPY;  end
            c_OP_NOT:  w_alu_sel = c_ALU_NOT;
            c_OP_SHR:  w_alu_sel = c_ALU_SHR;
            c_OP_SHL:  w_alu_sel = c_ALU_SHL;
            default:   w_alu_sel = c_ALU_PASS;
        endcase
        w_two_step = w_mem_alu || (w_nxt_opcode == c_OP_STORE);
    end

    // Next state and opcode. Dispatch in E0 reads only the opcode register.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_opcode = (r_state == S_F3) ? i_ir_cu : r_opcode;
        case (r_state)
            S_IDLE:   w_nxt_state = i_start ? S_F0 : S_IDLE;
            S_F0:     w_nxt_state = S_F1;
            S_F1:     w_nxt_state = S_F2;
            S_F2:     w_nxt_state = S_F3;
            S_F3:     w_nxt_state = S_F4;
            S_F4:     w_nxt_state = S_F5;
            S_F5:     w_nxt_state = S_E0;
            S_E0: begin
                if (w_two_step)
                    w_nxt_state = S_E1;
                else if (r_opcode == c_OP_HALT)
                    w_nxt_state = S_HALTED;
                else
                    w_nxt_state = S_F0;
            end
            S_E1:     w_nxt_state = S_F0;
            S_HALTED: w_nxt_state = S_HALTED;
            default:  w_nxt_state = S_IDLE;
        endcase
    end

    // Output word for the state being entered.
    always_comb begin
        w_nxt_ctrl   = 16'h0000;
        w_nxt_alu_op = c_ALU_PASS;
        w_nxt_done   = 1'b0;
        w_nxt_jmpgez = 1'b0;
        case (w_nxt_state)
            S_F0: w_nxt_ctrl = c_C0;
            S_F1: w_nxt_ctrl = c_C1 | c_C2;
            S_F2: w_nxt_ctrl = c_C4;
            S_F3: w_nxt_ctrl = c_C14;
            S_F4: w_nxt_ctrl = c_C15;
            S_F5: w_nxt_ctrl = c_C9;
            S_E0: begin
                w_nxt_done = !w_two_step;
                if (w_mem_alu) begin
                    w_nxt_ctrl = c_C1;
                end else begin
                    case (w_nxt_opcode)
                        c_OP_STORE:  w_nxt_ctrl = c_C7;
                        c_OP_JMP:    w_nxt_ctrl = c_C3;
                        c_OP_JMPGEZ: w_nxt_jmpgez = 1'b1;
                        c_OP_NOT, c_OP_SHR, c_OP_SHL: begin
                            w_nxt_ctrl   = c_C6;
                            w_nxt_alu_op = w_alu_sel;
                        end
                        default:     w_nxt_ctrl = 16'h0000;
                    endcase
                end
            end
            S_E1: begin
                w_nxt_done = 1'b1;
                if (w_mem_alu) begin
                    w_nxt_ctrl   = c_C5 | c_C6;
                    w_nxt_alu_op = w_alu_sel;
                end else begin
                    w_nxt_ctrl = c_C8;
                end
            end
            default: w_nxt_ctrl = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_opcode    <= 8'h00;
            r_ctrl      <= 16'h0000;
            r_alu_op    <= c_ALU_PASS;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_halted    <= 1'b0;
            r_jmpgez_e0 <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_opcode    <= w_nxt_opcode;
            r_ctrl      <= w_nxt_ctrl;
            r_alu_op    <= w_nxt_alu_op;
            r_busy      <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_HALTED);
            r_done      <= w_nxt_done;
            r_halted    <= (w_nxt_state == S_HALTED);
            r_jmpgez_e0 <= w_nxt_jmpgez;
        end
    end

    // JMPGEZ takes the branch on the sign flag seen during E0 itself, so C3
    // is the only bit qualified after the register.
    assign o_ctrl       = r_ctrl | ((r_jmpgez_e0 && i_acc_nonneg) ? c_C3 : 16'h0000);
    assign o_alu_op     = r_alu_op;
    assign o_busy       = r_busy;
    assign o_instr_done = r_done;
    assign o_halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer. A table of
//                instructions is run back-to-back after one start pulse,
//                followed by directed HALT and asynchronous-reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [7:0]  i_ir_cu;
    logic        i_acc_nonneg;
    logic [15:0] o_ctrl;
    logic [3:0]  o_alu_op;
    logic        o_busy;
    logic        o_instr_done;
    logic        o_halted;

    control_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_ir_cu      (i_ir_cu),
        .i_acc_nonneg (i_acc_nonneg),
        .o_ctrl       (o_ctrl),
        .o_alu_op     (o_alu_op),
        .o_busy       (o_busy),
        .o_instr_done (o_instr_done),
        .o_halted     (o_halted)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [7:0]  op;
        logic        acc;
        int          len;
        logic [15:0] e0_ctrl;
        logic [3:0]  e0_alu;
        logic [15:0] e1_ctrl;
        logic [3:0]  e1_alu;
    } vec_t;

    localparam int c_NVEC = 17;
    vec_t        vecs [c_NVEC];
    logic [15:0] fetch_words [6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at the falling edge of an F0 cycle; leaves at the falling edge
    // of the cycle after the instruction's last step.
    task automatic run_instr(input int idx);
        vec_t        v;
        logic [15:0] exp_ctrl;
        logic [3:0]  exp_alu;
        logic        exp_done;
        v = vecs[idx];
        i_acc_nonneg = v.acc;
        for (int k = 0; k < v.len; k++) begin
            if (k < 6)       exp_ctrl = fetch_words[k];
            else if (k == 6) exp_ctrl = v.e0_ctrl;
            else             exp_ctrl = v.e1_ctrl;
            exp_alu  = (k == 6) ? v.e0_alu : ((k == 7) ? v.e1_alu : 4'd0);
            exp_done = (k == v.len - 1);
            check($sformatf("v%0d op%02h step%0d ctrl", idx, v.op, k), {16'h0, o_ctrl}, {16'h0, exp_ctrl});
            check($sformatf("v%0d op%02h step%0d alu", idx, v.op, k), {28'h0, o_alu_op}, {28'h0, exp_alu});
            check($sformatf("v%0d op%02h step%0d busy/done/halted", idx, v.op, k),
                  {29'h0, o_busy, o_instr_done, o_halted}, {29'h0, 1'b1, exp_done, 1'b0});
            // Opcode is only valid while C14 is out; a stray start mid-fetch must be ignored.
            i_ir_cu = (k == 3) ? v.op : 8'hAA;
            i_start = (k == 2);
            @(negedge i_clk);
        end
        i_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fetch_words[0] = 16'h0001;
        fetch_words[1] = 16'h0006;
        fetch_words[2] = 16'h0010;
        fetch_words[3] = 16'h4000;
        fetch_words[4] = 16'h8000;
        fetch_words[5] = 16'h0200;

        //             op     acc   len e0_ctrl   alu   e1_ctrl   alu
        vecs[0]  = '{8'h02, 1'b1, 8, 16'h0002, 4'd0, 16'h0060, 4'd0}; // LOAD
        vecs[1]  = '{8'h01, 1'b1, 8, 16'h0080, 4'd0, 16'h0100, 4'd0}; // STORE
        vecs[2]  = '{8'h03, 1'b0, 8, 16'h0002, 4'd0, 16'h0060, 4'd1}; // ADD
        vecs[3]  = '{8'h04, 1'b1, 8, 16'h0002, 4'd0, 16'h0060, 4'd2}; // SUB
        vecs[4]  = '{8'h09, 1'b1, 8, 16'h0002, 4'd0, 16'h0060, 4'd3}; // AND
        vecs[5]  = '{8'h0A, 1'b0, 8, 16'h0002, 4'd0, 16'h0060, 4'd4}; // OR
        vecs[6]  = '{8'h08, 1'b1, 8, 16'h0002, 4'd0, 16'h0060, 4'd8}; // MPY
        vecs[7]  = '{8'h0B, 1'b1, 7, 16'h0040, 4'd5, 16'h0000, 4'd0}; // NOT
        vecs[8]  = '{8'h0C, 1'b0, 7, 16'h0040, 4'd6, 16'h0000, 4'd0}; // SHR
        vecs[9]  = '{8'h0D, 1'b1, 7, 16'h0040, 4'd7, 16'h0000, 4'd0}; // SHL
        vecs[10] = '{8'h06, 1'b0, 7, 16'h0008, 4'd0, 16'h0000, 4'd0}; // JMP
        vecs[11] = '{8'h05, 1'b1, 7, 16'h0008, 4'd0, 16'h0000, 4'd0}; // JMPGEZ taken
        vecs[12] = '{8'h05, 1'b0, 7, 16'h0000, 4'd0, 16'h0000, 4'd0}; // JMPGEZ not taken
        vecs[13] = '{8'hFF, 1'b1, 7, 16'h0000, 4'd0, 16'h0000, 4'd0}; // NOP (FF)
        vecs[14] = '{8'h00, 1'b1, 7, 16'h0000, 4'd0, 16'h0000, 4'd0}; // NOP (00)
        vecs[15] = '{8'h0E, 1'b0, 7, 16'h0000, 4'd0, 16'h0000, 4'd0}; // NOP (0E)
        vecs[16] = '{8'h07, 1'b1, 7, 16'h0000, 4'd0, 16'h0000, 4'd0}; // HALT

        i_rst = 1'b1;
        i_start = 1'b0;
        i_ir_cu = 8'h00;
        i_acc_nonneg = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("reset ctrl", {16'h0, o_ctrl}, 32'h0);
        check("reset alu/busy/done/halted", {27'h0, o_alu_op, o_busy, o_instr_done, o_halted}, 32'h0);

        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("idle hold ctrl", {16'h0, o_ctrl}, 32'h0);
        check("idle hold busy", {31'h0, o_busy}, 32'h0);

        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;

        // All table entries back-to-back; HALT is last.
        for (int i = 0; i < c_NVEC; i++) run_instr(i);

        // HALTED from the 8th cycle of the HALT instruction.
        check("halted ctrl", {16'h0, o_ctrl}, 32'h0);
        check("halted status", {27'h0, o_alu_op, o_busy, o_instr_done, o_halted}, 32'h1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        check("halted ignores start ctrl", {16'h0, o_ctrl}, 32'h0);
        check("halted ignores start status", {29'h0, o_busy, o_instr_done, o_halted}, 32'h1);

        // Reset exits HALTED.
        #2 i_rst = 1'b1;
        #1;
        check("reset from halted", {29'h0, o_busy, o_instr_done, o_halted}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check("idle after halt reset", {16'h0, o_ctrl, o_busy, o_halted}, 32'h0);

        // Asynchronous reset during F4.
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("restart F0", {16'h0, o_ctrl}, 32'h0001);
        repeat (4) @(negedge i_clk);
        check("reached F4", {16'h0, o_ctrl}, 32'h8000);
        #2 i_rst = 1'b1;
        #1;
        check("async reset ctrl", {16'h0, o_ctrl}, 32'h0);
        check("async reset busy", {31'h0, o_busy}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("idle after abort ctrl", {16'h0, o_ctrl}, 32'h0);
        check("idle after abort busy", {31'h0, o_busy}, 32'h0);

        // New start runs a full LOAD, then fetch resumes immediately.
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        run_instr(0);
        check("back-to-back F0", {16'h0, o_ctrl}, 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
